// File: rtl/duck_hit_ctl.sv
// rtl/duck_hit_ctl.sv - shot/hit controller: click detection, hit test, bullets, score
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   game_enable       : game running; low returns the controller to IDLE
//   mouse_xpos/ypos   : cursor position (12 bit)
//   mouse_left        : left button level, synchronous to clk
//   duck_xpos/ypos    : duck bounding-box top-left (12 bit)
//   target_killed     : one-cycle pulse on a registered hit
//   duck_escaped      : one-cycle pulse when the last bullet misses
//   duck_hit          : level, high for the whole KILLED phase
//   bullets_left      : remaining bullets for the current duck
//   score             : hit count, saturating at 255
module duck_hit_ctl #(
    parameter int DUCK_WIDTH      = 96,
    parameter int DUCK_HEIGHT     = 32,
    parameter int BULLETS         = 3,
    parameter int COOLDOWN_CYCLES = 650000,
    parameter int HOLD_CYCLES     = 6500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_enable,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic [11:0] duck_xpos,
    input  logic [11:0] duck_ypos,
    output logic        target_killed,
    output logic        duck_escaped,
    output logic        duck_hit,
    output logic [1:0]  bullets_left,
    output logic [7:0]  score
);

    localparam int MAX_CYC = (COOLDOWN_CYCLES > HOLD_CYCLES) ? COOLDOWN_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The counter is loaded with N-1 on entry and the phase ends when it reads
    // zero, so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] COOL_LOAD    = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]       BULLETS_INIT = 2'(BULLETS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_SHOT,
        ST_COOLDOWN,
        ST_KILLED,
        ST_ESCAPE
    } state_t;

    state_t           state_q, state_d;
    logic             mouse_left_q;
    logic [11:0]      mx_q, my_q, dx_q, dy_q;
    logic [1:0]       bullets_q, bullets_d;
    logic [7:0]       score_q, score_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             target_killed_q, target_killed_d;
    logic             duck_escaped_q, duck_escaped_d;
    logic             duck_hit_q, duck_hit_d;
    logic             latch_en;
    logic             click;
    logic             hit;

    assign click = mouse_left & ~mouse_left_q;

    // Hit test on the coordinates latched at the click, widened to 13 bits so
    // the box end never wraps.
    logic [12:0] dx_end, dy_end;
    assign dx_end = {1'b0, dx_q} + 13'(DUCK_WIDTH);
    assign dy_end = {1'b0, dy_q} + 13'(DUCK_HEIGHT);
    assign hit = (mx_q >= dx_q) && ({1'b0, mx_q} < dx_end) &&
                 (my_q >= dy_q) && ({1'b0, my_q} < dy_end);

    always_comb begin
        state_d         = state_q;
        bullets_d       = bullets_q;
        score_d         = score_q;
        cnt_d           = cnt_q;
        target_killed_d = 1'b0;
        duck_escaped_d  = 1'b0;
        duck_hit_d      = 1'b0;
        latch_en        = 1'b0;

        if (!game_enable) begin
            // Abort: pulses dropped, counter cleared, score kept.
            state_d   = ST_IDLE;
            bullets_d = BULLETS_INIT;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bullets_d = BULLETS_INIT;
                    score_d   = 8'd0;
                    state_d   = ST_READY;
                end
                ST_READY: begin
                    if (click) begin
                        latch_en  = 1'b1;
                        bullets_d = bullets_q - 2'd1;
                        state_d   = ST_SHOT;
                    end
                end
                ST_SHOT: begin
                    if (hit) begin
                        state_d         = ST_KILLED;
                        target_killed_d = 1'b1;
                        duck_hit_d      = 1'b1;
                        cnt_d           = HOLD_LOAD;
                        score_d         = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end else if (bullets_q == 2'd0) begin
                        state_d        = ST_ESCAPE;
                        duck_escaped_d = 1'b1;
                        cnt_d          = HOLD_LOAD;
                    end else begin
                        state_d = ST_COOLDOWN;
                        cnt_d   = COOL_LOAD;
                    end
                end
                ST_COOLDOWN: begin
                    if (cnt_q == '0) begin
                        state_d = ST_READY;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_KILLED: begin
                    if (cnt_q == '0) begin
                        state_d   = ST_READY;
                        bullets_d = BULLETS_INIT;
                    end else begin
                        duck_hit_d = 1'b1;
                        cnt_d      = cnt_q - CNT_W'(1);
                    end
                end
                ST_ESCAPE: begin
                    if (cnt_q == '0) begin
                        state_d   = ST_READY;
                        bullets_d = BULLETS_INIT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            mouse_left_q    <= 1'b0;
            mx_q            <= 12'd0;
            my_q            <= 12'd0;
            dx_q            <= 12'd0;
            dy_q            <= 12'd0;
            bullets_q       <= BULLETS_INIT;
            score_q         <= 8'd0;
            cnt_q           <= '0;
            target_killed_q <= 1'b0;
            duck_escaped_q  <= 1'b0;
            duck_hit_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            mouse_left_q    <= mouse_left;
            bullets_q       <= bullets_d;
            score_q         <= score_d;
            cnt_q           <= cnt_d;
            target_killed_q <= target_killed_d;
            duck_escaped_q  <= duck_escaped_d;
            duck_hit_q      <= duck_hit_d;
            if (latch_en) begin
                mx_q <= mouse_xpos;
                my_q <= mouse_ypos;
                dx_q <= duck_xpos;
                dy_q <= duck_ypos;
            end
        end
    end

    assign target_killed = target_killed_q;
    assign duck_escaped  = duck_escaped_q;
    assign duck_hit      = duck_hit_q;
    assign bullets_left  = bullets_q;
    assign score         = score_q;

endmodule

// File: tb/tb_duck_hit_ctl.sv
// tb/tb_duck_hit_ctl.sv - scoreboard bench for duck_hit_ctl
module tb_duck_hit_ctl;

    localparam int DW  = 96;
    localparam int DH  = 32;
    localparam int NB  = 3;
    localparam int CDC = 5;
    localparam int HLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_enable;
    logic [11:0] mouse_xpos, mouse_ypos, duck_xpos, duck_ypos;
    logic        mouse_left;
    logic        target_killed, duck_escaped, duck_hit;
    logic [1:0]  bullets_left;
    logic [7:0]  score;

    duck_hit_ctl #(
        .DUCK_WIDTH(DW), .DUCK_HEIGHT(DH), .BULLETS(NB),
        .COOLDOWN_CYCLES(CDC), .HOLD_CYCLES(HLD)
    ) dut (
        .clk(clk), .rst(rst), .game_enable(game_enable),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_left(mouse_left),
        .duck_xpos(duck_xpos), .duck_ypos(duck_ypos),
        .target_killed(target_killed), .duck_escaped(duck_escaped), .duck_hit(duck_hit),
        .bullets_left(bullets_left), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tk;
        int esc;
        int dh;
        int bl;
        int sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_bl     = NB;
    int   m_sc     = 0;
    int   duck_x   = 400;
    int   duck_y   = 300;
    int   prev_bl  = NB;
    bit   pend     = 1'b0;

    task automatic check_eq(input string tag, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, req, $time);
        end
    endtask

    // Outcome monitor: a bullets_left decrement marks the SHOT cycle; the
    // following cycle carries the outcome and is checked against the queue.
    always @(negedge clk) begin
        if (pend) begin
            check_eq("shot_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check_eq("target_killed", target_killed, exp_q[0].tk);
                check_eq("duck_escaped", duck_escaped, exp_q[0].esc);
                check_eq("duck_hit_rise", duck_hit, exp_q[0].dh);
                check_eq("bullets_after_shot", bullets_left, exp_q[0].bl);
                check_eq("score_after_shot", score, exp_q[0].sc);
                void'(exp_q.pop_front());
            end
        end
        pend    <= !rst && (int'(bullets_left) < prev_bl);
        prev_bl <= int'(bullets_left);
    end

    // mode: 0 plain, 1 keep button held through the next READY, 2 abort mid-KILLED
    task automatic shoot(input int mx, input int my, input int mode);
        bit   is_hit;
        exp_t e;
        is_hit = (mx >= duck_x) && (mx < duck_x + DW) && (my >= duck_y) && (my < duck_y + DH);
        m_bl   = m_bl - 1;
        if (is_hit) m_sc = (m_sc == 255) ? 255 : m_sc + 1;
        e.tk  = int'(is_hit);
        e.esc = int'(!is_hit && m_bl == 0);
        e.dh  = int'(is_hit);
        e.bl  = m_bl;
        e.sc  = m_sc;
        exp_q.push_back(e);

        mouse_xpos = 12'(mx);
        mouse_ypos = 12'(my);
        mouse_left = 1'b1;
        @(negedge clk);
        if (mode != 1) mouse_left = 1'b0;
        // move the duck away during SHOT; the latched position must be used
        duck_xpos = 12'(duck_x) ^ 12'h800;
        duck_ypos = 12'(duck_y) ^ 12'h400;
        @(negedge clk);
        duck_xpos = 12'(duck_x);
        duck_ypos = 12'(duck_y);

        if (mode == 2) begin
            repeat (2) @(negedge clk);
            game_enable = 1'b0;
            @(negedge clk);
            check_eq("abort_duck_hit", duck_hit, 0);
            check_eq("abort_bullets", bullets_left, NB);
            check_eq("abort_score_kept", score, m_sc);
            check_eq("abort_pulse", target_killed, 0);
            m_bl = NB;
            repeat (3) @(negedge clk);
            check_eq("idle_score_kept", score, m_sc);
            game_enable = 1'b1;
            @(negedge clk);
            check_eq("reenable_score_clear", score, 0);
            m_sc = 0;
        end else if (is_hit || m_bl == 0) begin
            repeat (HLD - 1) @(negedge clk);
            check_eq("hold_last_duck_hit", duck_hit, int'(is_hit));
            check_eq("hold_last_bullets", bullets_left, m_bl);
            @(negedge clk);
            check_eq("ready_duck_hit", duck_hit, 0);
            check_eq("ready_reload", bullets_left, NB);
            check_eq("ready_no_escape", duck_escaped, 0);
            m_bl = NB;
            if (mode == 1) begin
                repeat (3) @(negedge clk);
                check_eq("held_button_one_shot", bullets_left, NB);
                mouse_left = 1'b0;
                @(negedge clk);
            end
        end else begin
            // extra click during COOLDOWN must be discarded
            mouse_left = 1'b1;
            @(negedge clk);
            mouse_left = 1'b0;
            repeat (CDC - 1) @(negedge clk);
            check_eq("cooldown_bullets_kept", bullets_left, m_bl);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        game_enable = 1'b0;
        mouse_left  = 1'b0;
        mouse_xpos  = 12'd0;
        mouse_ypos  = 12'd0;
        duck_xpos   = 12'(duck_x);
        duck_ypos   = 12'(duck_y);
        repeat (3) @(negedge clk);
        check_eq("rst_bullets", bullets_left, NB);
        check_eq("rst_score", score, 0);
        check_eq("rst_target_killed", target_killed, 0);
        check_eq("rst_duck_escaped", duck_escaped, 0);
        check_eq("rst_duck_hit", duck_hit, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_bullets", bullets_left, NB);
        game_enable = 1'b1;
        @(negedge clk);
        check_eq("enable_score", score, 0);

        shoot(450, 310, 0);     // plain hit, first cycle of READY
        shoot(496, 310, 0);     // right edge: miss
        shoot(400, 300, 0);     // top-left corner: hit, first READY after cooldown
        shoot(495, 331, 0);     // bottom-right inside: hit

        shoot(10, 10, 0);       // three misses -> escape
        shoot(450, 332, 0);
        shoot(399, 300, 0);

        while (m_sc < 255) shoot(450, 310, 0);
        shoot(450, 310, 0);     // saturated
        shoot(450, 310, 1);     // button held into READY

        shoot(450, 310, 2);     // abort mid-KILLED
        shoot(450, 310, 0);

        repeat (3) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
